// File: rtl/shift_accum_sequencer_if.sv
// Signal bundle around the shift-accumulate sequencer: run control, pixel
// input, the RAM request/result path and the readout code stream.
//
// Readout stream handshake (code_*): a word transfers on every cycle where
// code_valid_out && code_ready_in. Once code_valid_out is high, the payload
// (code_out, code_addr_out) holds until that transfer. Valid never waits on
// ready.
interface shift_accum_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 16,
  parameter int FW    = 4
);
  // Run control
  logic             start_in;
  logic             abort_in;
  logic [7:0]       threshold_in;
  // Pixel stream
  logic             frame_start_in;
  logic             pixel_valid_in;
  logic [7:0]       pixel_luma_in;
  logic [AW-1:0]    pixel_addr_in;
  // RAM request
  logic [AW-1:0]    addr_out;
  logic             summand_out;
  logic             request_type_out;
  logic             request_valid_out;
  // RAM result
  logic             result_valid_in;
  logic             result_type_in;
  logic [AW-1:0]    result_addr_in;
  logic [WIDTH-1:0] read_in;
  // Readout stream
  logic             code_valid_out;
  logic             code_ready_in;
  logic [WIDTH-1:0] code_out;
  logic [AW-1:0]    code_addr_out;
  // Status and debug
  logic             busy_out;
  logic [FW-1:0]    frame_count_out;
  logic [2:0]       state_out;

  // Sequencer side
  modport master (
    input  start_in, abort_in, threshold_in,
    input  frame_start_in, pixel_valid_in, pixel_luma_in, pixel_addr_in,
    output addr_out, summand_out, request_type_out, request_valid_out,
    input  result_valid_in, result_type_in, result_addr_in, read_in,
    output code_valid_out, code_out, code_addr_out,
    input  code_ready_in,
    output busy_out, frame_count_out, state_out
  );

  // Environment side (pixel source, RAM, code consumer)
  modport slave (
    output start_in, abort_in, threshold_in,
    output frame_start_in, pixel_valid_in, pixel_luma_in, pixel_addr_in,
    input  addr_out, summand_out, request_type_out, request_valid_out,
    output result_valid_in, result_type_in, result_addr_in, read_in,
    input  code_valid_out, code_out, code_addr_out,
    output code_ready_in,
    input  busy_out, frame_count_out, state_out
  );
endinterface

// File: rtl/shift_accum_sequencer.sv
// Upstream controller for the shift-accumulate RAM. Captures WIDTH frames of
// thresholded pixels as WRITE requests, then sweeps the RAM with READ
// requests and streams {addr, code} out through a credit-limited skid FIFO.
module shift_accum_sequencer #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 57600,
  parameter int CREDITS = 4
) (
  input logic                     clk_in,
  input logic                     rst_in,
  shift_accum_sequencer_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(WIDTH + 1);
  localparam int CW = $clog2(CREDITS + 1);
  localparam int PW = (CREDITS > 1) ? $clog2(CREDITS) : 1;
  localparam int EW = AW + WIDTH;

  localparam logic [AW:0]    DEPTH_W   = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0]  LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [FW-1:0]  FRAMES    = FW'(WIDTH);
  localparam logic [CW:0]    CREDITS_W = (CW + 1)'(CREDITS);
  localparam logic [PW-1:0]  LAST_PTR  = PW'(CREDITS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_CAPTURE = 3'd2,
    S_DRAIN   = 3'd3,
    S_READOUT = 3'd4
  } state_t;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } accum_request_t;

  state_t         state_q, state_d;
  logic [7:0]     thr_q, thr_d;
  logic [FW-1:0]  frame_cnt_q, frame_cnt_d;
  logic [1:0]     drain_cnt_q, drain_cnt_d;
  logic [AW-1:0]  rd_addr_q, rd_addr_d;
  logic           rd_done_q, rd_done_d;
  logic [CW-1:0]  inflight_q, inflight_d;

  logic           req_valid_q, req_valid_d;
  accum_request_t req_type_q, req_type_d;
  logic [AW-1:0]  req_addr_q, req_addr_d;
  logic           summand_q, summand_d;

  logic [EW-1:0]  fifo_mem_q [CREDITS];
  logic [EW-1:0]  fifo_mem_d [CREDITS];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  fifo_cnt_q, fifo_cnt_d;

  logic           pix_ok;
  logic           pix_last;
  logic           capture_pix;
  logic [CW:0]    credit_sum;
  logic           issue;
  logic           push;
  logic           pop;
  logic [EW-1:0]  head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Request and FIFO qualifiers derived from current state and inputs
  always_comb begin
    pix_ok      = bus.pixel_valid_in && ({1'b0, bus.pixel_addr_in} < DEPTH_W);
    pix_last    = (bus.pixel_addr_in == LAST_ADDR);
    // The pixel that carries frame_start_in is the first one captured; once
    // the last frame has been counted, stragglers are dropped.
    capture_pix = pix_ok &&
                  (((state_q == S_ARM) && bus.frame_start_in) ||
                   ((state_q == S_CAPTURE) && (frame_cnt_q != FRAMES)));
    credit_sum  = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
    // Every READ in flight already owns a FIFO slot, so the FIFO cannot overflow.
    issue       = (state_q == S_READOUT) && !rd_done_q && (credit_sum < CREDITS_W);
    // Only results for reads this run is waiting on are accepted; WRITE
    // results and leftovers from an aborted run fall through.
    push        = (state_q == S_READOUT) && bus.result_valid_in &&
                  (bus.result_type_in == REQ_READ) && (inflight_q != '0);
    pop         = (fifo_cnt_q != '0) && bus.code_ready_in;
    head        = fifo_mem_q[rd_ptr_q];
  end

  // Next-state logic for the sequencer FSM, request register and skid FIFO
  always_comb begin
    state_d     = state_q;
    thr_d       = thr_q;
    frame_cnt_d = frame_cnt_q;
    drain_cnt_d = drain_cnt_q;
    rd_addr_d   = rd_addr_q;
    rd_done_d   = rd_done_q;
    inflight_d  = inflight_q;
    req_valid_d = 1'b0;
    req_type_d  = REQ_READ;
    req_addr_d  = '0;
    summand_d   = 1'b0;
    fifo_mem_d  = fifo_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_cnt_d  = fifo_cnt_q;

    if (push) begin
      fifo_mem_d[wr_ptr_q] = {bus.result_addr_in, bus.read_in};
      wr_ptr_d             = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);

    if (capture_pix) begin
      req_valid_d = 1'b1;
      req_type_d  = REQ_WRITE;
      req_addr_d  = bus.pixel_addr_in;
      summand_d   = (bus.pixel_luma_in >= thr_q);
      if (pix_last) begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.start_in) begin
          state_d     = S_ARM;
          thr_d       = bus.threshold_in;
          frame_cnt_d = '0;
          rd_done_d   = 1'b0;
          inflight_d  = '0;
          wr_ptr_d    = '0;
          rd_ptr_d    = '0;
          fifo_cnt_d  = '0;
        end
      end
      S_ARM: begin
        if (capture_pix) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (frame_cnt_q == FRAMES) begin
          state_d     = S_DRAIN;
          drain_cnt_d = '0;
        end
      end
      S_DRAIN: begin
        // Three quiet cycles so the last WRITE lands before the first READ.
        drain_cnt_d = drain_cnt_q + 1'b1;
        if (drain_cnt_q == 2'd2) begin
          state_d   = S_READOUT;
          rd_addr_d = '0;
          rd_done_d = 1'b0;
        end
      end
      S_READOUT: begin
        if (issue) begin
          req_valid_d = 1'b1;
          req_type_d  = REQ_READ;
          req_addr_d  = rd_addr_q;
          if (rd_addr_q == LAST_ADDR) begin
            rd_done_d = 1'b1;
          end else begin
            rd_addr_d = rd_addr_q + 1'b1;
          end
        end
        inflight_d = inflight_q + CW'(issue) - CW'(push);
        if (rd_done_q && (inflight_q == '0) && (fifo_cnt_q == '0)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything, including a same-cycle start.
    if (bus.abort_in) begin
      state_d     = S_IDLE;
      req_valid_d = 1'b0;
      req_type_d  = REQ_READ;
      req_addr_d  = '0;
      summand_d   = 1'b0;
      rd_done_d   = 1'b0;
      inflight_d  = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      fifo_cnt_d  = '0;
    end
  end

  // State, request and FIFO registers
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= S_IDLE;
      thr_q       <= '0;
      frame_cnt_q <= '0;
      drain_cnt_q <= '0;
      rd_addr_q   <= '0;
      rd_done_q   <= 1'b0;
      inflight_q  <= '0;
      req_valid_q <= 1'b0;
      req_type_q  <= REQ_READ;
      req_addr_q  <= '0;
      summand_q   <= 1'b0;
      fifo_mem_q  <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      thr_q       <= thr_d;
      frame_cnt_q <= frame_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      rd_addr_q   <= rd_addr_d;
      rd_done_q   <= rd_done_d;
      inflight_q  <= inflight_d;
      req_valid_q <= req_valid_d;
      req_type_q  <= req_type_d;
      req_addr_q  <= req_addr_d;
      summand_q   <= summand_d;
      fifo_mem_q  <= fifo_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
    end
  end

  assign bus.addr_out          = req_addr_q;
  assign bus.summand_out       = summand_q;
  assign bus.request_type_out  = req_type_q;
  assign bus.request_valid_out = req_valid_q;
  assign bus.code_valid_out    = (fifo_cnt_q != '0);
  assign bus.code_out          = head[WIDTH-1:0];
  assign bus.code_addr_out     = head[EW-1:WIDTH];
  assign bus.busy_out          = (state_q != S_IDLE);
  assign bus.frame_count_out   = frame_cnt_q;
  assign bus.state_out         = state_q;
endmodule
